// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ADD/SUB/OR/AND ALU between NUM_REQ requesters, one operation in flight.
// Build option: define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration (default is round-robin).
module alu_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ALU_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_instruction,
  input  logic [NUM_REQ*8-1:0]   req_input_0,
  input  logic [NUM_REQ*8-1:0]   req_input_1,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   rsp_error,
  output logic                   alu_enable,
  output logic [7:0]             alu_instruction,
  output logic [7:0]             alu_input_0,
  output logic [7:0]             alu_input_1,
  input  logic [7:0]             alu_result,
  output logic                   arb_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [3:0]         cnt;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [7:0]         sel_instr;
  logic [7:0]         sel_in0;
  logic [7:0]         sel_in1;
  logic               sel_legal;
  logic [IDX_W-1:0]   ptr_next;

  // Search upward from the pointer with wrap-around; with the pointer pinned
  // at 0 this degenerates to plain lowest-index priority.
  always_comb begin
    int unsigned j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_valid[j[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = j[IDX_W-1:0];
      end
    end
  end

  assign win_onehot   = NUM_REQ'(1) << win_idx;
  assign owner_onehot = NUM_REQ'(1) << owner;
  assign sel_instr    = req_instruction[{win_idx, 3'b000} +: 8];
  assign sel_in0      = req_input_0[{win_idx, 3'b000} +: 8];
  assign sel_in1      = req_input_1[{win_idx, 3'b000} +: 8];
  assign sel_legal    = (sel_instr[7:2] == 6'd0);
  assign ptr_next     = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      owner           <= '0;
      cnt             <= '0;
      req_ready       <= '0;
      rsp_valid       <= '0;
      rsp_data        <= '0;
      rsp_error       <= 1'b0;
      alu_enable      <= 1'b0;
      alu_instruction <= '0;
      alu_input_0     <= '0;
      alu_input_1     <= '0;
      arb_busy        <= 1'b0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      alu_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            owner           <= win_idx;
            alu_instruction <= sel_instr;
            alu_input_0     <= sel_in0;
            alu_input_1     <= sel_in1;
            req_ready       <= win_onehot;
            arb_busy        <= 1'b1;
            if (sel_legal) begin
              alu_enable <= 1'b1;
              state      <= ST_ISSUE;
            end else begin
              // Illegal opcode: accept and answer together, the ALU is never touched.
              rsp_valid <= win_onehot;
              rsp_error <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_RESPOND;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= 4'(ALU_LATENCY);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            rsp_data  <= alu_result;
            rsp_error <= 1'b0;
            rsp_valid <= owner_onehot;
            state     <= ST_RESPOND;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESPOND: begin
          rsp_data  <= '0;
          rsp_error <= 1'b0;
          arb_busy  <= 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
          ptr       <= '0;
`else
          ptr       <= ptr_next;
`endif
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
  a_enable_issue: assert property (@(posedge clk) disable iff (reset) alu_enable == (state == ST_ISSUE));
  a_busy_state:   assert property (@(posedge clk) disable iff (reset) arb_busy == (state != ST_IDLE));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses, a negedge monitor pops and compares.
module tb_alu_arbiter;
  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned ALU_LATENCY = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ*8-1:0] req_instruction = '0;
  logic [NUM_REQ*8-1:0] req_input_0 = '0;
  logic [NUM_REQ*8-1:0] req_input_1 = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [7:0]           rsp_data;
  logic                 rsp_error;
  logic                 alu_enable;
  logic [7:0]           alu_instruction;
  logic [7:0]           alu_input_0;
  logic [7:0]           alu_input_1;
  logic [7:0]           alu_result = '0;
  logic                 arb_busy;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ALU_LATENCY(ALU_LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_instruction(req_instruction),
    .req_input_0(req_input_0), .req_input_1(req_input_1),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_error(rsp_error),
    .alu_enable(alu_enable), .alu_instruction(alu_instruction),
    .alu_input_0(alu_input_0), .alu_input_1(alu_input_1),
    .alu_result(alu_result), .arb_busy(arb_busy)
  );

  // Stand-in for the shared ALU: result appears after the enable edge and then holds.
  always @(posedge clk) begin
    if (alu_enable) begin
      case (alu_instruction)
        8'h00:   alu_result <= alu_input_0 + alu_input_1;
        8'h01:   alu_result <= alu_input_0 - alu_input_1;
        8'h02:   alu_result <= alu_input_0 | alu_input_1;
        8'h03:   alu_result <= alu_input_0 & alu_input_1;
        default: alu_result <= 8'h00;
      endcase
    end
  end

  typedef struct packed {
    logic [NUM_REQ-1:0] vld;
    logic [7:0]         data;
    logic               err;
  } exp_t;

  exp_t        sb[$];
  int unsigned grants[$];
  int unsigned gcyc[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned en_count = 0;

  // Hand-computed vectors used by the concurrent requesters.
  logic [7:0] v_op  [8] = '{8'h00, 8'h02, 8'h01, 8'h03, 8'h00, 8'h02, 8'h01, 8'h03};
  logic [7:0] v_a   [8] = '{8'h10, 8'h0F, 8'h50, 8'hCC, 8'hFF, 8'h81, 8'h00, 8'h3C};
  logic [7:0] v_b   [8] = '{8'h20, 8'hF0, 8'h10, 8'hAA, 8'h02, 8'h18, 8'h01, 8'h0F};
  logic [7:0] v_exp [8] = '{8'h30, 8'hFF, 8'h40, 8'h88, 8'h01, 8'h99, 8'hFF, 8'h0C};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!reset && alu_enable) en_count++;

  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid_bits", 64'(rsp_valid), 64'(e.vld));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_error", 64'(rsp_error), 64'(e.err));
      end
    end
  end

  task automatic drive(input int unsigned idx, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    req_instruction[idx*8 +: 8] = op;
    req_input_0[idx*8 +: 8]     = a;
    req_input_1[idx*8 +: 8]     = b;
  endtask

  task automatic single_op(input int unsigned idx, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_data, input logic exp_err);
    int unsigned n;
    int unsigned m;
    int unsigned en0;
    logic        seen;
    n = 0; m = 0; en0 = en_count;
    drive(idx, op, a, b);
    req_valid[idx] = 1'b1;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      seen = req_ready[idx];
    end
    check("ready_latency", 64'(n), 64'd1);
    if (!seen) begin
      req_valid[idx] = 1'b0;
      return;
    end
    check("ready_onehot", 64'(req_ready), 64'(NUM_REQ'(1) << idx));
    sb.push_back('{vld: NUM_REQ'(1) << idx, data: exp_data, err: exp_err});
    req_valid[idx] = 1'b0;
    seen = rsp_valid[idx];
    while (!seen && m < 40) begin
      @(posedge clk); #1;
      m++;
      seen = rsp_valid[idx];
    end
    check("rsp_latency", 64'(m), exp_err ? 64'd0 : 64'(ALU_LATENCY + 1));
    check("rsp_data_direct", 64'(rsp_data), 64'(exp_data));
    check("rsp_error_direct", 64'(rsp_error), 64'(exp_err));
    @(negedge clk);
    check("alu_enable_pulses", 64'(en_count - en0), exp_err ? 64'd0 : 64'd1);
  endtask

  task automatic requester(input int unsigned idx, input int unsigned first, input int unsigned n);
    int unsigned v;
    int unsigned waited;
    logic        seen;
    for (int unsigned k = 0; k < n; k++) begin
      v = first + k;
      drive(idx, v_op[v], v_a[v], v_b[v]);
      req_valid[idx] = 1'b1;
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 200) begin
        @(posedge clk); #1;
        waited++;
        seen = req_ready[idx];
      end
      if (!seen) begin
        check("grant_timeout", 64'(seen), 64'd1);
        req_valid[idx] = 1'b0;
        return;
      end
      sb.push_back('{vld: NUM_REQ'(1) << idx, data: v_exp[v], err: 1'b0});
      grants.push_back(idx);
      gcyc.push_back(cyc);
    end
    req_valid[idx] = 1'b0;
  endtask

  task automatic check_grants(input int unsigned exp_order[5], input int unsigned cnt);
    check("grant_count", 64'(grants.size()), 64'(cnt));
    for (int unsigned i = 0; i < cnt && i < grants.size(); i++) begin
      check("grant_order", 64'(grants[i]), 64'(exp_order[i]));
      if (i > 0) check("grant_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(ALU_LATENCY + 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned exp_fair[5];
    int unsigned exp_13[5];
    int unsigned en0;
    int unsigned n;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_fair = '{0, 0, 1, 2, 3};
    exp_13   = '{1, 1, 3, 0, 0};
`else
    exp_fair = '{0, 1, 2, 3, 0};
    exp_13   = '{1, 3, 1, 0, 0};
`endif
    #1;
    check("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_error, alu_enable,
                                alu_instruction, alu_input_0, alu_input_1, arb_busy}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    single_op(0, 8'h00, 8'h05, 8'h03, 8'h08, 1'b0);
    repeat (2) @(posedge clk); #1;
    single_op(2, 8'h01, 8'h02, 8'h05, 8'hFD, 1'b0);
    repeat (2) @(posedge clk); #1;
    single_op(1, 8'h07, 8'h11, 8'h22, 8'h00, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Abandon an operation in WAIT; no response may ever appear for it.
    drive(2, 8'h00, 8'h01, 8'h01);
    req_valid[2] = 1'b1;
    n = 0;
    while (!req_ready[2] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_grant", 64'(req_ready[2]), 64'd1);
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("busy_in_wait", 64'(arb_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_wait_outputs", 64'({req_ready, rsp_valid, rsp_data, rsp_error, alu_enable,
                                         alu_instruction, alu_input_0, alu_input_1, arb_busy}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    grants.delete(); gcyc.delete();
    en0 = en_count;
    fork
      requester(0, 0, 2);
      requester(1, 2, 1);
      requester(2, 3, 1);
      requester(3, 4, 1);
    join
    repeat (ALU_LATENCY + 4) @(posedge clk); #1;
    check_grants(exp_fair, 5);
    check("fair_enables", 64'(en_count - en0), 64'd5);

    grants.delete(); gcyc.delete();
    fork
      requester(1, 5, 2);
      requester(3, 7, 1);
    join
    repeat (ALU_LATENCY + 4) @(posedge clk); #1;
    check_grants(exp_13, 3);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
